frame_desc_fifo: RTL and testbench



---
 rtl/frame_desc_fifo.sv | 191 +++++++++++++++++++
 tb/tb_frame_desc_fifo.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/frame_desc_fifo.sv
// -----------------------------------------------------------------------------
// frame_desc_fifo
//   Show-ahead FIFO carrying frame-buffer descriptors (YUV plane base addresses,
//   picture metadata) from the video decoder to the display scan-out path.
//   The head entry is always presented on a registered q output, so a consumer
//   can pop on every cycle without bubbles.
//
// Parameters
//   WIDTH            descriptor width in bits
//   DEPTH            number of entries, power of two, 2..256
//   AFULL_THRESH     almost_full asserts when cnt >= this value
//   OVERWRITE_OLDEST 1: a write into a full FIFO discards the oldest entry
//                    0: such a write is dropped
//
// Ports
//   clk            clock
//   reset          synchronous, active-high reset
//   wdata / we     descriptor and push strobe
//   strobe         pop strobe, consumes q
//   flush          discard all entries (beats we/strobe)
//   err_clear      clear the sticky error flags
//   valid / q      head-valid flag and registered head entry
//   cnt            entries held, 0..DEPTH
//   full           cnt == DEPTH
//   almost_full    cnt >= AFULL_THRESH
//   overflow_err   sticky: write while full (without a simultaneous pop)
//   underflow_err  sticky: strobe while empty
//   hwm            high-water mark of cnt (only with FRAME_DESC_FIFO_HWM_EN)
//
// Optional feature macro: FRAME_DESC_FIFO_HWM_EN
//   Adds the hwm output: the largest post-edge cnt seen since the last reset
//   or err_clear. err_clear reloads it with the post-edge cnt.
// -----------------------------------------------------------------------------
module frame_desc_fifo #(
  parameter int WIDTH            = 64,
  parameter int DEPTH            = 16,
  parameter int AFULL_THRESH     = DEPTH - 2,
  parameter int OVERWRITE_OLDEST = 0
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [WIDTH-1:0]             wdata,
  input  logic                         we,
  input  logic                         strobe,
  input  logic                         flush,
  input  logic                         err_clear,
  output logic                         valid,
  output logic [WIDTH-1:0]             q,
  output logic [$clog2(DEPTH+1)-1:0]   cnt,
  output logic                         full,
  output logic                         almost_full,
  output logic                         overflow_err,
  output logic                         underflow_err
`ifdef FRAME_DESC_FIFO_HWM_EN
  ,
  output logic [$clog2(DEPTH+1)-1:0]   hwm
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] LP_DEPTH = CW'(DEPTH);
  localparam logic [CW-1:0] LP_AFULL = CW'(AFULL_THRESH);
  localparam logic          LP_OW    = (OVERWRITE_OLDEST != 0);
  localparam logic          LP_AF0   = (AFULL_THRESH == 0);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wptr;
  logic [AW-1:0]    r_rptr;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_q;
  logic             r_valid;
  logic             r_full;
  logic             r_afull;
  logic             r_ovf;
  logic             r_unf;

  logic             w_empty;
  logic             w_is_full;
  logic             w_pop;
  logic             w_unf_set;
  logic             w_ovf_set;
  logic             w_wr;
  logic             w_rd;
  logic [AW-1:0]    w_rptr_nxt;
  logic [CW-1:0]    w_cnt_nxt;
  logic [WIDTH-1:0] w_head;

  assign w_empty   = (r_cnt == '0);
  assign w_is_full = (r_cnt == LP_DEPTH);

  // A pop only happens when something is held; an empty strobe is an underflow.
  assign w_pop     = strobe & ~w_empty;
  assign w_unf_set = strobe & w_empty & ~flush;
  // A pop in the same cycle frees the slot, so that case is not an overflow.
  assign w_ovf_set = we & w_is_full & ~w_pop & ~flush;
  assign w_wr      = we & (~w_is_full | w_pop | LP_OW) & ~flush;
  // The head advances on a pop, or when overwrite mode evicts the oldest entry.
  assign w_rd      = w_pop | (w_ovf_set & LP_OW);

  assign w_rptr_nxt = w_rd ? (r_rptr + AW'(1)) : r_rptr;

  always_comb begin
    w_cnt_nxt = r_cnt;
    case ({w_wr, w_rd})
      2'b10:   w_cnt_nxt = r_cnt + CW'(1);
      2'b01:   w_cnt_nxt = r_cnt - CW'(1);
      default: w_cnt_nxt = r_cnt;
    endcase
  end

  // Bypass: when the slot that becomes head is the one written this edge, the
  // RAM still holds stale data, so forward wdata straight into q.
  assign w_head = (w_wr && (w_rptr_nxt == r_wptr)) ? wdata : r_mem[w_rptr_nxt];

  always_ff @(posedge clk) begin
    if (w_wr && !reset) begin
      r_mem[r_wptr] <= wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_cnt   <= '0;
      r_valid <= 1'b0;
      r_q     <= '0;
      r_full  <= 1'b0;
      r_afull <= LP_AF0;
    end else if (flush) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_cnt   <= '0;
      r_valid <= 1'b0;
      r_full  <= 1'b0;
      r_afull <= LP_AF0;
    end else begin
      if (w_wr) begin
        r_wptr <= r_wptr + AW'(1);
      end
      r_rptr  <= w_rptr_nxt;
      r_cnt   <= w_cnt_nxt;
      r_valid <= (w_cnt_nxt != '0);
      r_full  <= (w_cnt_nxt == LP_DEPTH);
      r_afull <= (w_cnt_nxt >= LP_AFULL);
      if (w_cnt_nxt != '0) begin
        r_q <= w_head;
      end
    end
  end

  // Sticky error flags: a new error in the same cycle as err_clear wins.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_ovf <= 1'b0;
      r_unf <= 1'b0;
    end else begin
      r_ovf <= w_ovf_set | (r_ovf & ~err_clear);
      r_unf <= w_unf_set | (r_unf & ~err_clear);
    end
  end

  assign valid         = r_valid;
  assign q             = r_q;
  assign cnt           = r_cnt;
  assign full          = r_full;
  assign almost_full   = r_afull;
  assign overflow_err  = r_ovf;
  assign underflow_err = r_unf;

`ifdef FRAME_DESC_FIFO_HWM_EN
  logic [CW-1:0] r_hwm;
  logic [CW-1:0] w_cnt_post;

  assign w_cnt_post = flush ? '0 : w_cnt_nxt;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_hwm <= '0;
    end else if (err_clear) begin
      r_hwm <= w_cnt_post;
    end else if (w_cnt_post > r_hwm) begin
      r_hwm <= w_cnt_post;
    end
  end

  assign hwm = r_hwm;
`endif

endmodule

// File: tb/tb_frame_desc_fifo.sv
// -----------------------------------------------------------------------------
// tb_frame_desc_fifo
//   Bench for frame_desc_fifo. Instance u_a: DEPTH=16, WIDTH=64, drop-on-full,
//   checked against a queue scoreboard after every edge. Instance u_b: DEPTH=4,
//   overwrite-oldest mode, directed checks.
// -----------------------------------------------------------------------------
module tb_frame_desc_fifo;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- instance A ----------------
  logic        a_reset = 1'b0;
  logic [63:0] a_wdata = '0;
  logic        a_we = 1'b0, a_strobe = 1'b0, a_flush = 1'b0, a_errclr = 1'b0;
  logic        a_valid, a_full, a_afull, a_ovf, a_unf;
  logic [63:0] a_q;
  logic [4:0]  a_cnt;
`ifdef FRAME_DESC_FIFO_HWM_EN
  logic [4:0]  a_hwm;
`endif

  frame_desc_fifo #(.WIDTH(64), .DEPTH(16), .AFULL_THRESH(14), .OVERWRITE_OLDEST(0)) u_a (
    .clk(clk), .reset(a_reset), .wdata(a_wdata), .we(a_we), .strobe(a_strobe),
    .flush(a_flush), .err_clear(a_errclr), .valid(a_valid), .q(a_q), .cnt(a_cnt),
    .full(a_full), .almost_full(a_afull), .overflow_err(a_ovf), .underflow_err(a_unf)
`ifdef FRAME_DESC_FIFO_HWM_EN
    , .hwm(a_hwm)
`endif
  );

  // ---------------- instance B ----------------
  logic        b_reset = 1'b0;
  logic [63:0] b_wdata = '0;
  logic        b_we = 1'b0, b_strobe = 1'b0, b_flush = 1'b0, b_errclr = 1'b0;
  logic        b_valid, b_full, b_afull, b_ovf, b_unf;
  logic [63:0] b_q;
  logic [2:0]  b_cnt;
`ifdef FRAME_DESC_FIFO_HWM_EN
  logic [2:0]  b_hwm;
`endif

  frame_desc_fifo #(.WIDTH(64), .DEPTH(4), .AFULL_THRESH(2), .OVERWRITE_OLDEST(1)) u_b (
    .clk(clk), .reset(b_reset), .wdata(b_wdata), .we(b_we), .strobe(b_strobe),
    .flush(b_flush), .err_clear(b_errclr), .valid(b_valid), .q(b_q), .cnt(b_cnt),
    .full(b_full), .almost_full(b_afull), .overflow_err(b_ovf), .underflow_err(b_unf)
`ifdef FRAME_DESC_FIFO_HWM_EN
    , .hwm(b_hwm)
`endif
  );

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // ---------------- scoreboard for instance A ----------------
  logic [63:0] sb[$];
  logic        m_ovf = 1'b0;
  logic        m_unf = 1'b0;
  int          m_hwm = 0;

  task automatic model_a(input logic we, input logic [63:0] wd, input logic st,
                         input logic fl, input logic ec);
    logic ovf_set, unf_set, pop, was_full;
    ovf_set = 1'b0;
    unf_set = 1'b0;
    if (fl) begin
      sb.delete();
    end else begin
      pop      = st && (sb.size() > 0);
      unf_set  = st && (sb.size() == 0);
      was_full = (sb.size() == 16);
      if (pop) void'(sb.pop_front());
      if (we) begin
        if (!was_full || pop) sb.push_back(wd);
        else ovf_set = 1'b1;
      end
    end
    m_ovf = ovf_set | (m_ovf & ~ec);
    m_unf = unf_set | (m_unf & ~ec);
    if (ec) m_hwm = sb.size();
    else if (sb.size() > m_hwm) m_hwm = sb.size();
  endtask

  task automatic check_a(input string tag);
    chk({tag, ".valid"}, 64'(a_valid), 64'(sb.size() > 0));
    chk({tag, ".cnt"},   64'(a_cnt),   64'(sb.size()));
    chk({tag, ".full"},  64'(a_full),  64'(sb.size() == 16));
    chk({tag, ".afull"}, 64'(a_afull), 64'(sb.size() >= 14));
    chk({tag, ".ovf"},   64'(a_ovf),   64'(m_ovf));
    chk({tag, ".unf"},   64'(a_unf),   64'(m_unf));
    if (sb.size() > 0) chk({tag, ".q"}, a_q, sb[0]);
`ifdef FRAME_DESC_FIFO_HWM_EN
    chk({tag, ".hwm"}, 64'(a_hwm), 64'(m_hwm));
`endif
  endtask

  // One clock edge on instance A with the given inputs, then model + check.
  task automatic step_a(input string tag, input logic we, input logic [63:0] wd,
                        input logic st, input logic fl, input logic ec);
    a_we = we; a_wdata = wd; a_strobe = st; a_flush = fl; a_errclr = ec;
    @(posedge clk); #1;
    model_a(we, wd, st, fl, ec);
    a_we = 1'b0; a_strobe = 1'b0; a_flush = 1'b0; a_errclr = 1'b0;
    check_a(tag);
  endtask

  task automatic step_b(input logic we, input logic [63:0] wd, input logic st);
    b_we = we; b_wdata = wd; b_strobe = st;
    @(posedge clk); #1;
    b_we = 1'b0; b_strobe = 1'b0;
  endtask

  initial begin
    #2;
    // ---- reset both instances ----
    a_reset = 1'b1; b_reset = 1'b1;
    a_we = 1'b1; a_wdata = 64'h55; a_strobe = 1'b1;  // reset must override these
    @(posedge clk); #1;
    @(posedge clk); #1;
    a_reset = 1'b0; b_reset = 1'b0; a_we = 1'b0; a_strobe = 1'b0;
    sb.delete(); m_ovf = 1'b0; m_unf = 1'b0; m_hwm = 0;
    chk("rst.q", a_q, 64'h0);
    check_a("rst");
    chk("rst_b.valid", 64'(b_valid), 64'h0);
    chk("rst_b.afull", 64'(b_afull), 64'h0);

    // ---- fill 16, overflow, drain in order ----
    for (int i = 0; i < 16; i++) step_a("fill", 1'b1, 64'h1000 + 64'(i), 1'b0, 1'b0, 1'b0);
    chk("fill.full", 64'(a_full), 64'h1);
    chk("fill.cnt", 64'(a_cnt), 64'd16);
    step_a("ovf", 1'b1, 64'hDEAD, 1'b0, 1'b0, 1'b0);
    chk("ovf.flag", 64'(a_ovf), 64'h1);
    chk("ovf.cnt", 64'(a_cnt), 64'd16);
    for (int i = 0; i < 16; i++) begin
      chk("drain.q", a_q, 64'h1000 + 64'(i));
      step_a("drain", 1'b0, 64'h0, 1'b1, 1'b0, 1'b0);
    end
    chk("drain.valid", 64'(a_valid), 64'h0);
    step_a("clr", 1'b0, 64'h0, 1'b0, 1'b0, 1'b1);
    chk("clr.ovf", 64'(a_ovf), 64'h0);

    // ---- single write latency and pop ----
    step_a("one", 1'b1, 64'hA5, 1'b0, 1'b0, 1'b0);
    chk("one.valid", 64'(a_valid), 64'h1);
    chk("one.q", a_q, 64'hA5);
    step_a("one_pop", 1'b0, 64'h0, 1'b1, 1'b0, 1'b0);
    chk("one_pop.valid", 64'(a_valid), 64'h0);
    chk("one_pop.cnt", 64'(a_cnt), 64'h0);

    // ---- simultaneous push/pop at cnt=3 ----
    step_a("abc", 1'b1, 64'hA, 1'b0, 1'b0, 1'b0);
    step_a("abc", 1'b1, 64'hB, 1'b0, 1'b0, 1'b0);
    step_a("abc", 1'b1, 64'hC, 1'b0, 1'b0, 1'b0);
    begin
      logic [63:0] exp_q [4];
      exp_q[0] = 64'hB; exp_q[1] = 64'hC; exp_q[2] = 64'hD; exp_q[3] = 64'hE;
      for (int i = 0; i < 4; i++) begin
        step_a("rw", 1'b1, 64'hD + 64'(i), 1'b1, 1'b0, 1'b0);
        chk("rw.cnt", 64'(a_cnt), 64'd3);
        chk("rw.q", a_q, exp_q[i]);
      end
    end
    step_a("fl0", 1'b0, 64'h0, 1'b0, 1'b1, 1'b0);

    // ---- underflow and sticky clear ----
    step_a("unf", 1'b0, 64'h0, 1'b1, 1'b0, 1'b0);
    chk("unf.flag", 64'(a_unf), 64'h1);
    chk("unf.cnt", 64'(a_cnt), 64'h0);
    step_a("unf_ec", 1'b0, 64'h0, 1'b1, 1'b0, 1'b1);
    chk("unf_ec.flag", 64'(a_unf), 64'h1);
    step_a("unf_clr", 1'b0, 64'h0, 1'b0, 1'b0, 1'b1);
    chk("unf_clr.flag", 64'(a_unf), 64'h0);

    // ---- flush beats write at cnt=10 ----
    for (int i = 0; i < 10; i++) step_a("ten", 1'b1, 64'h200 + 64'(i), 1'b0, 1'b0, 1'b0);
    chk("ten.cnt", 64'(a_cnt), 64'd10);
    step_a("flush", 1'b1, 64'hBAD, 1'b0, 1'b1, 1'b0);
    chk("flush.cnt", 64'(a_cnt), 64'h0);
    chk("flush.valid", 64'(a_valid), 64'h0);
`ifdef FRAME_DESC_FIFO_HWM_EN
    chk("flush.hwm", 64'(a_hwm), 64'd10);
`endif

    // ---- almost_full rises exactly at cnt=14 ----
    for (int i = 0; i < 16; i++) begin
      step_a("af", 1'b1, 64'h300 + 64'(i), 1'b0, 1'b0, 1'b0);
      chk("af.edge", 64'(a_afull), 64'(i + 1 >= 14));
    end
    step_a("af_pop", 1'b1, 64'h400, 1'b1, 1'b0, 1'b0);  // full + pop: no overflow
    chk("af_pop.ovf", 64'(a_ovf), 64'h0);
    chk("af_pop.cnt", 64'(a_cnt), 64'd16);

    // ---- random traffic against the scoreboard ----
    for (int i = 0; i < 400; i++) begin
      step_a("rnd", 1'($urandom_range(0, 1)), {$urandom, $urandom},
             1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 30) == 0),
             1'($urandom_range(0, 15) == 0));
    end

    // ---- instance B: overwrite-oldest ----
    for (int i = 1; i <= 4; i++) step_b(1'b1, 64'(i), 1'b0);
    chk("b.full", 64'(b_full), 64'h1);
    step_b(1'b1, 64'd5, 1'b0);
    chk("b.ow.q", b_q, 64'd2);
    chk("b.ow.cnt", 64'(b_cnt), 64'd4);
    chk("b.ow.ovf", 64'(b_ovf), 64'h1);
    for (int i = 2; i <= 5; i++) begin
      chk("b.pop.q", b_q, 64'(i));
      step_b(1'b0, 64'h0, 1'b1);
    end
    chk("b.empty.cnt", 64'(b_cnt), 64'h0);
    chk("b.empty.valid", 64'(b_valid), 64'h0);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
